// File: rtl/ccff_pkg.sv
// Shared types for the configuration-chain bitstream loader.
// Holds the FSM state encoding and the counter/index width helper.
package ccff_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    DONE,
    ERROR
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer that turns bitstream words into a bit-serial chain feed.
// Owns the occupancy count, s_ready and the head/shift-enable generation.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int WORD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic              flush,
  input  logic              final_shift,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              head,
  output logic              shift_en
);

  localparam int BW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sreg;
  logic [BW-1:0]     bits;
  logic              empty;
  logic              last_bit;
  logic              fire;

  assign empty    = (bits == '0);
  assign last_bit = (bits == BW'(1));
  assign shift_en = busy && !empty;
  assign head     = shift_en && sreg[0];

  // No word is taken on the very last shift of the operation
  assign s_ready = busy && !final_shift && (empty || last_bit);
  assign fire    = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      bits <= '0;
    end else if (fire) begin
      sreg <= s_data;
      bits <= BW'(WORD_W);
    end else if (flush) begin
      bits <= '0;
    end else if (shift_en) begin
      sreg <= sreg >> 1;
      bits <= bits - BW'(1);
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Writer end of the ccff configuration chain: load pass plus optional
// read-back verify pass comparing ccff_tail against the re-sent stream.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 10,
  parameter int WORD_W    = 4
) (
  input  logic                         prog_clk,
  input  logic                         pReset_n,
  input  logic                         start,
  input  logic                         verify_en,
  input  logic [WORD_W-1:0]            s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         ccff_head,
  output logic                         ccff_shift_en,
  input  logic                         ccff_tail,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [idx_w(CHAIN_LEN)-1:0]  err_idx
);

  localparam int CW = idx_w(CHAIN_LEN);

  state_e        state;
  state_e        state_nx;
  logic [CW-1:0] bit_cnt;
  logic          ver_q;
  logic          mis_q;
  logic          go;
  logic          pass_end;
  logic          final_shift;
  logic          mismatch;

  assign busy  = (state == LOAD) || (state == VERIFY);
  assign done  = (state == DONE);
  assign error = (state == ERROR);
  assign go    = start && !busy;

  assign pass_end    = ccff_shift_en && (bit_cnt == CW'(CHAIN_LEN - 1));
  assign final_shift = pass_end && ((state == VERIFY) || !ver_q);

  // Bit k of the load pass reaches the tail as bit k is re-sent
  assign mismatch = (state == VERIFY) && ccff_shift_en
                 && (ccff_tail != ccff_head);

  ccff_word_serializer #(
    .WORD_W(WORD_W)
  ) u_ser (
    .clk        (prog_clk),
    .rst_n      (pReset_n),
    .busy       (busy),
    .flush      (pass_end || go),
    .final_shift(final_shift),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .head       (ccff_head),
    .shift_en   (ccff_shift_en)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start) state_nx = LOAD;
      LOAD:   if (pass_end) state_nx = ver_q ? VERIFY : DONE;
      VERIFY: if (pass_end) state_nx = (mis_q || mismatch) ? ERROR : DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      ver_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_idx <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        bit_cnt <= '0;
        ver_q   <= verify_en;
        mis_q   <= 1'b0;
        err_idx <= '0;
      end else begin
        if (pass_end) begin
          bit_cnt <= '0;
        end else if (ccff_shift_en) begin
          bit_cnt <= bit_cnt + CW'(1);
        end
        if (mismatch && !mis_q) begin
          mis_q   <= 1'b1;
          err_idx <= bit_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: behavioural chain with read-back faults
// and a stream-level reference model of head bits, chain contents and flags.
module tb_ccff_bitstream_loader;

  localparam int N   = 10;
  localparam int W   = 4;
  localparam int WPP = (N + W - 1) / W;

  logic         prog_clk = 1'b0;
  logic         pReset_n = 1'b0;
  logic         start = 1'b0;
  logic         verify_en = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         ccff_head;
  logic         ccff_shift_en;
  logic         ccff_tail;
  logic         busy;
  logic         done;
  logic         error;
  logic [3:0]   err_idx;

  ccff_bitstream_loader #(
    .CHAIN_LEN(N),
    .WORD_W   (W)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .start        (start),
    .verify_en    (verify_en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_idx      (err_idx)
  );

  always #5 prog_clk = ~prog_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural chain: N FFs, entry at [0], tail at [N-1]
  logic [N-1:0] chain = '0;
  int           sh_cnt = 0;
  int           fbase = 0;
  int           fk;
  logic [N-1:0] fault = '0;
  logic         tail_bit;

  always @(posedge prog_clk) begin
    if (ccff_shift_en) begin
      chain  <= {chain[N-2:0], ccff_head};
      sh_cnt <= sh_cnt + 1;
    end
  end

  // Read-back fault: config bit k reads as 0 when it leaves the tail
  always_comb begin
    fk       = sh_cnt - fbase - N;
    tail_bit = chain[N-1];
    if (fk >= 0 && fk < N) begin
      if (fault[fk]) tail_bit = 1'b0;
    end
  end
  assign ccff_tail = tail_bit;

  bit head_log[$];
  int hcyc[$];
  int cyc = 0;
  int log_base = 0;

  always @(negedge prog_clk) begin
    cyc <= cyc + 1;
    if (ccff_shift_en) begin
      head_log.push_back(ccff_head);
      hcyc.push_back(cyc + 1);
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] ws[$];

  function automatic logic [N-1:0] pass_bits(input int p);
    logic [N-1:0] b;
    logic [W-1:0] w;
    b = '0;
    for (int k = 0; k < N; k++) begin
      w    = ws[p * WPP + k / W];
      b[k] = w[k % W];
    end
    return b;
  endfunction

  function automatic int first_err();
    logic [N-1:0] b;
    b = pass_bits(0);
    for (int k = 0; k < N; k++) begin
      if (fault[k] && b[k]) return k;
    end
    return -1;
  endfunction

  task automatic pulse_start(input bit v);
    @(posedge prog_clk);
    #1;
    start     = 1'b1;
    verify_en = v;
    @(posedge prog_clk);
    #1;
    start     = 1'b0;
    verify_en = 1'b0;
  endtask

  task automatic begin_run(input bit v);
    log_base = head_log.size();
    fbase    = sh_cnt;
    pulse_start(v);
  endtask

  task automatic send_words(input int first, input int last,
                            input int gap_at, input int gap_len);
    bit ok;
    for (int i = first; i <= last; i++) begin
      if (i == gap_at && gap_len > 0) begin
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
          @(negedge prog_clk);
          #1;
          ok = s_ready;
        end
        repeat (gap_len) @(posedge prog_clk);
        #1;
      end
      s_data  = ws[i];
      s_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
        @(negedge prog_clk);
        #1;
        ok = s_ready;
      end
      check("ready_seen", 64'(ok), 64'(1));
      if (ok) @(posedge prog_clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_end();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge prog_clk);
      #1;
      ok = done || error;
    end
    check("end_seen", 64'(ok), 64'(1));
  endtask

  task automatic evaluate(input string tag, input bit v, input int exp_bub);
    int           n;
    int           ferr;
    bit           exp_err;
    logic [63:0]  obs;
    logic [63:0]  exp;
    logic [N-1:0] pb;
    logic [N-1:0] ec;
    n       = head_log.size() - log_base;
    ferr    = first_err();
    exp_err = v && (ferr >= 0);
    pb      = pass_bits(0);
    obs     = '0;
    exp     = '0;
    for (int i = 0; i < n && i < 64; i++) obs[i] = head_log[log_base + i];
    for (int p = 0; p < (v ? 2 : 1); p++) begin
      for (int k = 0; k < N; k++) exp[p * N + k] = pb[k];
    end
    for (int k = 0; k < N; k++) ec[N - 1 - k] = pb[k];
    check({tag, "_nshift"}, 64'(n), 64'(v ? 2 * N : N));
    check({tag, "_heads"}, obs, exp);
    check({tag, "_done"}, 64'(done), 64'(!exp_err));
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    check({tag, "_chain"}, 64'(chain), 64'(ec));
    if (n > 0) begin
      check({tag, "_lat"}, 64'(cyc - hcyc[hcyc.size() - 1]), 64'(1));
      if (!v) begin
        check({tag, "_bubbles"},
              64'(hcyc[hcyc.size() - 1] - hcyc[log_base] + 1 - n),
              64'(exp_bub));
      end
    end
    if (exp_err) check({tag, "_err_idx"}, 64'(err_idx), 64'(ferr));
  endtask

  task automatic load_fixed();
    ws.delete();
    for (int p = 0; p < 2; p++) begin
      ws.push_back(4'h5);
      ws.push_back(4'hA);
      ws.push_back(4'h3);
    end
  endtask

  task automatic load_random();
    ws.delete();
    for (int i = 0; i < 2 * WPP; i++) begin
      if (i < WPP) ws.push_back(W'($urandom_range(0, 15)));
      else ws.push_back(ws[i - WPP]);
    end
  endtask

  task automatic full_run(input string tag, input bit v,
                          input int gap_at, input int gap_len);
    begin_run(v);
    send_words(0, (v ? 2 : 1) * WPP - 1, gap_at, gap_len);
    wait_end();
    evaluate(tag, v, gap_len);
  endtask

  initial begin
    repeat (3) @(posedge prog_clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_shift_en", 64'(ccff_shift_en), 64'(0));
    check("rst_ready", 64'(s_ready), 64'(0));
    check("rst_flags", 64'({done, error, ccff_head}), 64'(0));
    check("rst_err_idx", 64'(err_idx), 64'(0));
    @(negedge prog_clk);
    pReset_n = 1'b1;

    load_fixed();
    full_run("s1", 1'b0, -1, 0);
    full_run("s2a", 1'b1, -1, 0);
    full_run("s2b", 1'b1, -1, 0);
    load_random();
    full_run("s2r", 1'b1, -1, 0);

    load_random();
    ws[1] = ws[1] | 4'h4;
    ws[2] = ws[2] | 4'h1;
    ws[4] = ws[1];
    ws[5] = ws[2];
    fault = '0;
    fault[6] = 1'b1;
    fault[8] = 1'b1;
    full_run("s3", 1'b1, -1, 0);
    fault = '0;

    load_fixed();
    begin_run(1'b0);
    check("s4_clr_error", 64'(error), 64'(0));
    check("s4_clr_err_idx", 64'(err_idx), 64'(0));
    send_words(0, WPP - 1, 2, 3);
    wait_end();
    evaluate("s4", 1'b0, 3);

    begin_run(1'b0);
    send_words(0, 1, -1, 0);
    check("s5_pre_shifts", 64'(head_log.size() - log_base), 64'(4));
    pReset_n = 1'b0;
    #1;
    check("s5_busy", 64'(busy), 64'(0));
    check("s5_shift_en", 64'(ccff_shift_en), 64'(0));
    check("s5_outs", 64'({s_ready, ccff_head, done, error, err_idx}),
          64'(0));
    @(negedge prog_clk);
    pReset_n = 1'b1;
    full_run("s5", 1'b0, -1, 0);

    begin_run(1'b0);
    send_words(0, 1, -1, 0);
    pulse_start(1'b1);
    check("s6_still_busy", 64'(busy), 64'(1));
    send_words(2, 2, -1, 0);
    wait_end();
    evaluate("s6", 1'b0, 0);
    begin_run(1'b0);
    check("s6_done_clr", 64'(done), 64'(0));
    check("s6_restart", 64'(busy), 64'(1));
    send_words(0, WPP - 1, -1, 0);
    wait_end();
    evaluate("s6b", 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      bit v;
      load_random();
      v     = 1'($urandom_range(0, 1));
      fault = N'($urandom) & N'($urandom);
      full_run($sformatf("rnd%0d", r), v, -1, 0);
      fault = '0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Writer end of the configuration-chain (ccff) protocol. Serializes a word-oriented bitstream onto the ccff_head of a tile's daisy-chained config flip-flops.
- Generates the per-cycle shift enable used to gate prog_clk into the chain.
- Optional verify pass re-streams the same bitstream and compares the chain's ccff_tail against it bit-for-bit.
- Sits between the bitstream source (DMA/JTAG bridge) and the tile ccff_head/ccff_tail pins.

Parameters:
- CHAIN_LEN, 10, number of config FFs in the chain (bits per pass); must be at least 1.
- WORD_W, 4, width of each input bitstream word.

Ports:
- prog_clk  input  1  programming clock; all state on the rising edge.
- pReset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- verify_en  input  1  sampled with start; 1 = run a verify pass after the load pass.
- s_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  word accepted when s_valid and s_ready are both high.
- ccff_head  output  1  serial data into the chain.
- ccff_shift_en  output  1  chain advances on this prog_clk edge; drives the external clock gate.
- ccff_tail  input  1  serial data out of the chain.
- busy  output  1  high in LOAD or VERIFY.
- done  output  1  sticky success flag; cleared by start.
- error  output  1  sticky verify-mismatch flag; cleared by start.
- err_idx  output  clog2(CHAIN_LEN)  bit index of the first mismatch.

Behaviour:
- Reset values: every output 0, state IDLE, word buffer empty, bit counter 0.
- States and transitions:
  - IDLE/DONE/ERROR -> LOAD on start. Clears done, error, err_idx and the counter; latches verify_en.
  - LOAD -> VERIFY when bit CHAIN_LEN-1 shifts and verify is latched.
  - LOAD -> DONE when bit CHAIN_LEN-1 shifts and verify is not latched.
  - VERIFY -> DONE after CHAIN_LEN shifts with no mismatch.
  - VERIFY -> ERROR after CHAIN_LEN shifts with at least one mismatch.
  - start while busy is ignored.
- Word buffer: one WORD_W shift register plus an occupancy bit-count.
  - s_ready = busy and (buffer empty, or last remaining bit shifts this cycle). Back-to-back words therefore stream with no bubble.
- Shift cycle: ccff_shift_en = busy and buffer holds at least 1 bit. ccff_head = current buffer bit 0 (combinational from the buffer). On the edge, buffer shifts right and the bit counter increments.
- Stall: buffer empty and no word arriving -> ccff_shift_en = 0, chain holds, ccff_head is don't-care (driven 0).
- Pass boundary: the counter wraps to 0 at CHAIN_LEN.
  - If CHAIN_LEN mod WORD_W != 0, leftover upper bits of a pass's final word are discarded (buffer flushed).
  - The next pass starts on a fresh word.
- Verify pass: the source re-sends the identical stream.
  - At verify shift k, ccff_tail must equal ccff_head, since bit k of pass 1 reaches the tail exactly CHAIN_LEN shifts after entry.
  - A mismatch sets error (sticky). err_idx captures k only for the first mismatch.
  - The verify pass still rewrites the same data, so the chain contents stay correct.
- done/error assert on the cycle after the final shift and hold until the next start.
- Reset mid-operation: immediate return to IDLE. ccff_shift_en drops asynchronously; chain contents are undefined and need a reload.
- Start and final shift in the same cycle cannot occur, because start is ignored while busy.

Decomposition:
- Shared package ccff_pkg holds:
  - the state enum (IDLE, LOAD, VERIFY, DONE, ERROR);
  - the width function for the counter and err_idx (clog2 of CHAIN_LEN).
- One natural sub-module: ccff_word_serializer. It owns the word buffer, the bit-count, s_ready, and the head/shift_en generation.
- The top holds the FSM, pass counter and compare.

Test Plan:
1. CHAIN_LEN=10, WORD_W=4, verify_en=0; words 0x5, 0xA, 0x3 sent back-to-back:
   - expect 10 shift_en cycles with no bubble;
   - head sequence 1,0,1,0,0,1,0,1,1,1 (upper 2 bits of 0x3 discarded);
   - done=1 one cycle after the last shift; a behavioural 10-FF chain model holds that sequence.
2. Same stream with verify_en=1, repeated, chain model attached:
   - 20 shifts, done=1, error=0.
3. Verify with chain model bit 6 forced stuck-at-0:
   - error=1, err_idx=6, done=0;
   - a later mismatch does not change err_idx.
4. s_valid held low 3 cycles between words 1 and 2:
   - shift_en=0 for exactly those cycles;
   - chain model unchanged during the stall;
   - final contents identical to scenario 1.
5. pReset_n asserted mid-LOAD after 4 shifts:
   - all outputs 0 immediately, state IDLE;
   - a new start reloads the full 10 bits and ends with done=1.
6. start pulsed while busy:
   - ignored, bit counter continues;
   - start in DONE clears done and begins a new pass.
